// File: rtl/dmem_pkg.sv
// Shared types, size constants and size helpers for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} dmem_state_t;

    localparam logic [3:0] SZ_B = 4'd1;
    localparam logic [3:0] SZ_H = 4'd2;
    localparam logic [3:0] SZ_W = 4'd4;
    localparam logic [3:0] SZ_D = 4'd8;

    // True for the four transfer sizes the port supports.
    function automatic logic size_legal(input logic [3:0] size);
        case (size)
            SZ_B, SZ_H, SZ_W, SZ_D: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

    // Byte-enable pattern for a transfer starting at lane 0.
    function automatic logic [7:0] size_byte_mask(input logic [3:0] size);
        case (size)
            SZ_B:    return 8'h01;
            SZ_H:    return 8'h03;
            SZ_W:    return 8'h0f;
            SZ_D:    return 8'hff;
            default: return 8'h00;
        endcase
    endfunction

    // Data mask keeping the low 'size' bytes of a 64-bit word.
    function automatic logic [63:0] size_data_mask(input logic [3:0] size);
        case (size)
            SZ_B:    return 64'h0000_0000_0000_00ff;
            SZ_H:    return 64'h0000_0000_0000_ffff;
            SZ_W:    return 64'h0000_0000_ffff_ffff;
            SZ_D:    return 64'hffff_ffff_ffff_ffff;
            default: return 64'h0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// Byte-writable 64-bit-wide storage: synchronous write, combinational read, no reset.
module dmem_byte_array #(
    parameter int unsigned DEPTH_BYTES = 1024,
    localparam int unsigned AW = (DEPTH_BYTES > 8) ? $clog2(DEPTH_BYTES / 8) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [7:0]    be,
    input  logic [AW-1:0] word_addr,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata
);

    logic [63:0] mem [0:(1 << AW) - 1];

    // Per-byte write into the addressed 8-byte word.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 8; i++) begin
                if (be[i]) begin
                    mem[word_addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[word_addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, programmable wait states, then a response.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [3:0]  req_size,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = (DEPTH_BYTES > 8) ? $clog2(DEPTH_BYTES / 8) : 1;

    dmem_state_t state;
    logic [3:0]  cnt;
    logic        lat_write;
    logic [63:0] lat_addr;
    logic [63:0] lat_wdata;
    logic [3:0]  lat_size;

    logic [64:0] end_addr;
    logic        misaligned;
    logic        range_err;
    logic        acc_err;
    logic        do_access;
    logic [5:0]  lane_shift;
    logic        arr_we;
    logic [7:0]  arr_be;
    logic [63:0] arr_wdata;
    logic [63:0] arr_rdata;
    logic [63:0] load_data;

    // Legality and lane steering, all from the latched request.
    always_comb begin
        // 65-bit sum so addresses near 2^64 cannot wrap back into range
        end_addr   = {1'b0, lat_addr} + {61'd0, lat_size};
        misaligned = (lat_addr[3:0] & (lat_size - 4'd1)) != 4'd0;
        range_err  = end_addr > 65'(DEPTH_BYTES);
        acc_err    = !size_legal(lat_size) || misaligned || range_err;
        do_access  = (state == BUSY) && (cnt == 4'd0);
        lane_shift = {lat_addr[2:0], 3'b000};
        arr_we     = do_access && lat_write && !acc_err;
        arr_be     = size_byte_mask(lat_size) << lat_addr[2:0];
        arr_wdata  = lat_wdata << lane_shift;
        load_data  = (arr_rdata >> lane_shift) & size_data_mask(lat_size);
    end

    dmem_byte_array #(
        .DEPTH_BYTES(DEPTH_BYTES)
    ) u_array (
        .clk      (clk),
        .we       (arr_we),
        .be       (arr_be),
        .word_addr(lat_addr[AW+2:3]),
        .wdata    (arr_wdata),
        .rdata    (arr_rdata)
    );

    // Request/wait/response sequencing with registered response fields.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_write <= 1'b0;
            lat_addr  <= 64'd0;
            lat_wdata <= 64'd0;
            lat_size  <= 4'd0;
            rsp_rdata <= 64'd0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_write <= req_write;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_size  <= req_size;
                        cnt       <= 4'(LATENCY);
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        rsp_err   <= acc_err;
                        rsp_rdata <= (acc_err || lat_write) ? 64'd0 : load_data;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_rdata <= 64'd0;
                        rsp_err   <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

endmodule
